// File: rtl/ptmch_pkg.sv
// ptmch_pkg: shared opcodes, FSM state and frame record for the SPI frame capture front end.
package ptmch_pkg;
    localparam logic [7:0] P_OP_WREN      = 8'h06;
    localparam logic [7:0] P_OP_PROG_LOAD = 8'h02;
    localparam logic [7:0] P_OP_PROG_EXEC = 8'h10;
    localparam logic [7:0] P_OP_PAGE_READ = 8'h13;
    // Record counter is sized for the widest supported P_DCNT_W; tops use the low bits.
    localparam int DCNT_MAX_W = 16;

    typedef enum logic [2:0] {SKIP, IDLE, OPC, ADDR, DATA} frm_state_t;

    typedef struct packed {
        logic [7:0]            opcode;
        logic [23:0]           addr;
        logic [DCNT_MAX_W-1:0] dcnt;
        logic                  known;
        logic                  ovf;
    } frm_rec_t;

    function automatic logic [1:0] addr_bytes(input logic [7:0] op);
        return op == P_OP_PROG_LOAD ? 2'd2 :
               (op == P_OP_PROG_EXEC || op == P_OP_PAGE_READ) ? 2'd3 : 2'd0;
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        return op == P_OP_WREN || addr_bytes(op) != 2'd0;
    endfunction
endpackage

// File: rtl/ptmch_spi_byte_shifter.sv
// ptmch_spi_byte_shifter: MSB-first MOSI deserialiser with bit counter and registered byte strobe.
module ptmch_spi_byte_shifter (
    input  logic       SPI_CLK,
    input  logic       RESET_N,
    input  logic       cs,
    input  logic       mosi,
    output logic       byte_done,
    output logic [7:0] byte_val,
    output logic       stb,
    output logic [7:0] data
);
    logic [6:0] shift;
    logic [2:0] bit_cnt;

    // byte_done/byte_val describe the byte completing on the current edge, so the FSM can act on it.
    assign byte_done = ~cs & (bit_cnt == 3'd7);
    assign byte_val  = {shift, mosi};

    always_ff @(posedge SPI_CLK) begin
        if (!RESET_N) begin
            shift   <= '0;
            bit_cnt <= '0;
            stb     <= 1'b0;
            data    <= '0;
        end else begin
            stb     <= byte_done;
            bit_cnt <= cs ? 3'd0 : bit_cnt + 3'd1;
            if (!cs) shift <= byte_val[6:0];
            if (byte_done) data <= byte_val;
        end
    end
endmodule

// File: rtl/ptmch_spi_frame_cap.sv
// ptmch_spi_frame_cap: SPI-NAND command frame decoder publishing one toggle-announced record per frame.
module ptmch_spi_frame_cap
    import ptmch_pkg::*;
#(
    parameter int P_DCNT_W = 12
) (
    input  logic                SPI_CLK,
    input  logic                RESET_N,
    input  logic                SPI_CS,
    input  logic                SPI_MOSI,
    output logic                BYTE_STB,
    output logic [7:0]          BYTE_DATA,
    output logic                FRM_TGL,
    output logic [7:0]          FRM_OPCODE,
    output logic [23:0]         FRM_ADDR,
    output logic [P_DCNT_W-1:0] FRM_DCNT,
    output logic                FRM_KNOWN,
    output logic                FRM_OVF
);
    localparam logic [DCNT_MAX_W-1:0] DCNT_SAT = DCNT_MAX_W'((64'd1 << P_DCNT_W) - 64'd1);

    frm_state_t state, state_d;
    frm_rec_t   cur, cur_d;
    logic [1:0] addr_left, left_d;
    logic       pub;
    logic       byte_done;
    logic [7:0] byte_val;

    ptmch_spi_byte_shifter u_shift (
        .SPI_CLK   (SPI_CLK),
        .RESET_N   (RESET_N),
        .cs        (SPI_CS),
        .mosi      (SPI_MOSI),
        .byte_done (byte_done),
        .byte_val  (byte_val),
        .stb       (BYTE_STB),
        .data      (BYTE_DATA)
    );

    always_comb begin
        state_d = state;
        cur_d   = cur;
        left_d  = addr_left;
        pub     = 1'b0;
        if (SPI_CS) begin
            state_d = IDLE;
            pub     = state == DATA;
        end else begin
            case (state)
                IDLE: begin
                    state_d = OPC;
                    cur_d   = '0;
                end
                OPC: if (byte_done) begin
                    cur_d.opcode = byte_val;
                    cur_d.known  = op_known(byte_val);
                    left_d       = addr_bytes(byte_val);
                    state_d      = left_d == 2'd0 ? SKIP : ADDR;
                    pub          = left_d == 2'd0;
                end
                ADDR: if (byte_done) begin
                    cur_d.addr = {cur.addr[15:0], byte_val};
                    left_d     = addr_left - 2'd1;
                    if (addr_left == 2'd1) begin
                        state_d = cur.opcode == P_OP_PROG_LOAD ? DATA : SKIP;
                        pub     = cur.opcode != P_OP_PROG_LOAD;
                    end
                end
                DATA: if (byte_done) begin
                    if (cur.dcnt == DCNT_SAT) cur_d.ovf = 1'b1;
                    else cur_d.dcnt = cur.dcnt + DCNT_MAX_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge SPI_CLK) begin
        if (!RESET_N) begin
            state      <= SKIP;
            cur        <= '0;
            addr_left  <= '0;
            FRM_TGL    <= 1'b0;
            FRM_OPCODE <= '0;
            FRM_ADDR   <= '0;
            FRM_DCNT   <= '0;
            FRM_KNOWN  <= 1'b0;
            FRM_OVF    <= 1'b0;
        end else begin
            state     <= state_d;
            cur       <= cur_d;
            addr_left <= left_d;
            if (pub) begin
                FRM_TGL    <= ~FRM_TGL;
                FRM_OPCODE <= cur_d.opcode;
                FRM_ADDR   <= cur_d.addr;
                FRM_DCNT   <= cur_d.dcnt[P_DCNT_W-1:0];
                FRM_KNOWN  <= cur_d.known;
                FRM_OVF    <= cur_d.ovf;
            end
        end
    end
endmodule

// File: tb/tb_ptmch_spi_frame_cap.sv
// tb_ptmch_spi_frame_cap: directed frame scenarios against two instances (P_DCNT_W 12 and 4).
module tb_ptmch_spi_frame_cap;
    logic        spi_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        stb, known, ovf, tgl;
    logic [7:0]  bdata, opc;
    logic [23:0] addr;
    logic [11:0] dcnt;
    logic        stb4, known4, ovf4, tgl4;
    logic [7:0]  bdata4, opc4;
    logic [23:0] addr4;
    logic [3:0]  dcnt4;
    int n_chk = 0;
    int n_pass = 0;
    int stb_cnt = 0;

    always #5 spi_clk = ~spi_clk;

    ptmch_spi_frame_cap #(.P_DCNT_W(12)) dut (
        .SPI_CLK(spi_clk), .RESET_N(reset_n), .SPI_CS(spi_cs), .SPI_MOSI(spi_mosi),
        .BYTE_STB(stb), .BYTE_DATA(bdata), .FRM_TGL(tgl), .FRM_OPCODE(opc),
        .FRM_ADDR(addr), .FRM_DCNT(dcnt), .FRM_KNOWN(known), .FRM_OVF(ovf)
    );

    ptmch_spi_frame_cap #(.P_DCNT_W(4)) dut4 (
        .SPI_CLK(spi_clk), .RESET_N(reset_n), .SPI_CS(spi_cs), .SPI_MOSI(spi_mosi),
        .BYTE_STB(stb4), .BYTE_DATA(bdata4), .FRM_TGL(tgl4), .FRM_OPCODE(opc4),
        .FRM_ADDR(addr4), .FRM_DCNT(dcnt4), .FRM_KNOWN(known4), .FRM_OVF(ovf4)
    );

    always @(negedge spi_clk) if (stb === 1'b1) stb_cnt++;

    task automatic send_bit(input logic b);
        @(negedge spi_clk);
        spi_cs = 1'b0;
        spi_mosi = b;
        @(posedge spi_clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic cs_high();
        @(negedge spi_clk);
        spi_cs = 1'b1;
        @(posedge spi_clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge spi_clk);
        #1;
        n_chk++; if ({tgl, opc, addr, dcnt, known, ovf} !== 54'd0) $display("FAIL reset_frm got %h want 0", {tgl, opc, addr, dcnt, known, ovf}); else n_pass++;
        n_chk++; if ({stb, bdata} !== 9'd0) $display("FAIL reset_byte got %h want 0", {stb, bdata}); else n_pass++;
        @(negedge spi_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_prog_exec();
        int s0;
        cs_high();
        s0 = stb_cnt;
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h12);
        n_chk++; if (tgl !== 1'b0) $display("FAIL exec_early_tgl got %b want 0", tgl); else n_pass++;
        send_byte(8'h34);
        n_chk++; if (tgl !== 1'b1) $display("FAIL exec_tgl got %b want 1", tgl); else n_pass++;
        n_chk++; if (opc !== 8'h10) $display("FAIL exec_opc got %h want 10", opc); else n_pass++;
        n_chk++; if (addr !== 24'h001234) $display("FAIL exec_addr got %h want 001234", addr); else n_pass++;
        n_chk++; if ({known, ovf, dcnt} !== {1'b1, 1'b0, 12'd0}) $display("FAIL exec_kod got %h want %h", {known, ovf, dcnt}, {1'b1, 1'b0, 12'd0}); else n_pass++;
        n_chk++; if ({stb, bdata} !== {1'b1, 8'h34}) $display("FAIL exec_byte got %h want 134", {stb, bdata}); else n_pass++;
        cs_high();
        n_chk++; if (stb_cnt - s0 !== 4) $display("FAIL exec_stb_cnt got %0d want 4", stb_cnt - s0); else n_pass++;
    endtask

    task automatic test_truncated();
        send_byte(8'h13);
        send_bits(16'h0FFF, 12);
        cs_high();
        n_chk++; if ({tgl, opc} !== {1'b1, 8'h10}) $display("FAIL trunc_hold got %h want 110", {tgl, opc}); else n_pass++;
        send_byte(8'h06);
        n_chk++; if ({tgl, opc, addr} !== {1'b0, 8'h06, 24'h0}) $display("FAIL trunc_wren got %h want %h", {tgl, opc, addr}, {1'b0, 8'h06, 24'h0}); else n_pass++;
        cs_high();
    endtask

    task automatic test_prog_load();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h40);
        for (int i = 1; i <= 5; i++) send_byte(8'(i * 17));
        n_chk++; if ({tgl, opc} !== {1'b0, 8'h06}) $display("FAIL load_early got %h want 006", {tgl, opc}); else n_pass++;
        cs_high();
        n_chk++; if (tgl !== 1'b1) $display("FAIL load_tgl got %b want 1", tgl); else n_pass++;
        n_chk++; if ({opc, addr} !== {8'h02, 24'h000040}) $display("FAIL load_oa got %h want 02000040", {opc, addr}); else n_pass++;
        n_chk++; if ({dcnt, ovf, known} !== {12'd5, 1'b0, 1'b1}) $display("FAIL load_dok got %h want %h", {dcnt, ovf, known}, {12'd5, 1'b0, 1'b1}); else n_pass++;
        n_chk++; if ({dcnt4, ovf4} !== {4'd5, 1'b0}) $display("FAIL load_d4 got %h want %h", {dcnt4, ovf4}, {4'd5, 1'b0}); else n_pass++;
    endtask

    task automatic test_wren_stray();
        send_byte(8'h06);
        n_chk++; if ({tgl, opc, addr, dcnt} !== {1'b0, 8'h06, 24'h0, 12'h0}) $display("FAIL wren_pub got %h want %h", {tgl, opc, addr, dcnt}, {1'b0, 8'h06, 24'h0, 12'h0}); else n_pass++;
        send_bits(16'h07FF, 11);
        cs_high();
        n_chk++; if ({tgl, opc} !== {1'b0, 8'h06}) $display("FAIL wren_stray got %h want 006", {tgl, opc}); else n_pass++;
    endtask

    task automatic test_unknown();
        send_byte(8'hAB);
        n_chk++; if ({tgl, opc, known, addr} !== {1'b1, 8'hAB, 1'b0, 24'h0}) $display("FAIL unk got %h want %h", {tgl, opc, known, addr}, {1'b1, 8'hAB, 1'b0, 24'h0}); else n_pass++;
        cs_high();
    endtask

    task automatic test_overflow();
        send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        for (int i = 0; i < 15; i++) send_byte(8'(i));
        cs_high();
        n_chk++; if ({tgl4, dcnt4, ovf4} !== {1'b0, 4'd15, 1'b0}) $display("FAIL sat15_d4 got %h want %h", {tgl4, dcnt4, ovf4}, {1'b0, 4'd15, 1'b0}); else n_pass++;
        send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        cs_high();
        n_chk++; if ({tgl4, addr4, dcnt4, ovf4} !== {1'b1, 24'h001234, 4'd15, 1'b1}) $display("FAIL ovf_d4 got %h want %h", {tgl4, addr4, dcnt4, ovf4}, {1'b1, 24'h001234, 4'd15, 1'b1}); else n_pass++;
        n_chk++; if ({dcnt, ovf} !== {12'd20, 1'b0}) $display("FAIL ovf_d12 got %h want %h", {dcnt, ovf}, {12'd20, 1'b0}); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h10);
        send_bits(16'h000A, 4);
        @(negedge spi_clk);
        reset_n = 1'b0;
        @(posedge spi_clk);
        #1;
        @(negedge spi_clk);
        reset_n = 1'b1;
        send_byte(8'h06); send_byte(8'h06);
        n_chk++; if ({tgl, opc, addr, dcnt, known, ovf} !== 54'd0) $display("FAIL rst_mid_quiet got %h want 0", {tgl, opc, addr, dcnt, known, ovf}); else n_pass++;
        cs_high();
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        n_chk++; if ({tgl, opc, addr, known} !== {1'b1, 8'h13, 24'h000007, 1'b1}) $display("FAIL rst_mid_next got %h want %h", {tgl, opc, addr, known}, {1'b1, 8'h13, 24'h000007, 1'b1}); else n_pass++;
        cs_high();
    endtask

    initial begin
        test_reset();
        test_prog_exec();
        test_truncated();
        test_prog_load();
        test_wren_stray();
        test_unknown();
        test_overflow();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ptmch_spi_frame_cap.md
Name: ptmch_spi_frame_cap

Overview:
- SPI-bus snooper front end, clocked by SPI_CLK.
- Deserialises MOSI into bytes, decodes SPI-NAND command framing (opcode, address bytes, data byte count) and publishes one record per completed frame.
- Record is held stable and announced by a toggle (FRM_TGL), so the CLK160M-domain trigger/match stages can consume it through a toggle synchroniser.
- Sits directly upstream of the PROGRAM_EXECUTE trigger logic.

Parameters:
- P_OP_WREN, 8'h06: write enable; opcode only, no address.
- P_OP_PROG_LOAD, 8'h02: program load; 2 address bytes, then variable data.
- P_OP_PROG_EXEC, 8'h10: program execute; 3 address bytes.
- P_OP_PAGE_READ, 8'h13: page read; 3 address bytes.
- P_DCNT_W, 12: width of the data byte counter.

Ports:
- SPI_CLK  in  1  bus clock; all logic on the rising edge.
- RESET_N  in  1  reset: synchronous, active-low, sampled on SPI_CLK.
- SPI_CS  in  1  chip select, active-low; sampled on SPI_CLK.
- SPI_MOSI  in  1  serial data, MSB first.
- BYTE_STB  out  1  one-cycle strobe, each completed byte.
- BYTE_DATA  out  8  last completed byte.
- FRM_TGL  out  1  toggles once per published frame.
- FRM_OPCODE  out  8  published opcode.
- FRM_ADDR  out  24  published address, right-aligned.
- FRM_DCNT  out  P_DCNT_W  published data byte count.
- FRM_KNOWN  out  1  opcode matched a parameter.
- FRM_OVF  out  1  data count saturated.

Behaviour:
- Reset: every output is 0. FSM enters SKIP and bit_cnt = 0. No capture until an edge with SPI_CS = 1 is seen, which discards any mid-frame tail.
- Inter-frame clocking: the bus master provides at least one SPI_CLK rising edge with SPI_CS = 1 between frames.
- Edge with SPI_CS = 1:
  - FSM goes to IDLE; bit_cnt = 0; partial byte is discarded.
  - If the FSM was in DATA, the frame is published on this edge.
  - A truncated frame (CS released in OPC or ADDR) is discarded, with no toggle.
- Edge with SPI_CS = 0:
  - shift = {shift[6:0], MOSI}; bit_cnt increments and wraps 7 -> 0.
  - The edge where bit_cnt == 7 completes a byte. At that edge, BYTE_DATA <= {shift[6:0], MOSI} and BYTE_STB <= 1; BYTE_STB is 0 on every other edge.
  - Byte strobes are also generated in SKIP.
- FSM states: SKIP, IDLE, OPC, ADDR, DATA.
  - IDLE -> OPC on the first CS=0 edge; that bit is bit 0.
  - OPC, on its completed byte:
    - opcode = WREN: publish now, ADDR = 0, -> SKIP.
    - opcode = PROG_LOAD: addr_left = 2, -> ADDR.
    - opcode = PROG_EXEC or PAGE_READ: addr_left = 3, -> ADDR.
    - any other opcode: publish now, KNOWN = 0, ADDR = 0, -> SKIP.
  - ADDR: each completed byte does addr = {addr[15:0], byte} and decrements addr_left. On the last byte:
    - PROG_LOAD -> DATA with dcnt = 0.
    - otherwise publish now and -> SKIP.
  - DATA: each completed byte increments dcnt, saturating at all-ones; an increment attempted at all-ones sets ovf. The frame is published on the next CS=1 edge.
  - SKIP: ignores bits until a CS=1 edge.
  - The address register is cleared on entry to OPC, so 2-byte addresses occupy [15:0] with [23:16] = 0.
- Publish: registered at the deciding edge. FRM_* fields load and FRM_TGL inverts on that same edge; fields are held until the next publish.
- Consumer rule: fields change only together with FRM_TGL, so the consumer samples them two or more CLK160M cycles after it detects the toggle.
- No other outputs change while the FSM is in SKIP or IDLE.

Decomposition:
- Package ptmch_pkg holds:
  - the opcode constants;
  - typedef enum frm_state_t {SKIP, IDLE, OPC, ADDR, DATA};
  - struct frm_rec_t {opcode, addr, dcnt, known, ovf}.
- Sub-module ptmch_spi_byte_shifter holds shift register, bit counter and byte strobe. Inputs: cs, mosi. Outputs: byte_done, byte. The FSM lives in the top.

Test Plan:
- Reset, one CS-high edge, then bytes 10 00 12 34 -> on edge 32, FRM_TGL 0->1, OPCODE 0x10, ADDR 0x001234, KNOWN 1, DCNT 0; 4 BYTE_STB pulses.
- Bytes 02 00 40 followed by 5 data bytes, then a CS-high edge -> toggle only at the CS-high edge; ADDR 0x000040, DCNT 5, OVF 0.
- Byte 06, then 11 stray bits, then CS high -> toggle at edge 8, OPCODE 0x06, ADDR 0; the stray bits do not publish.
- Byte 13 with CS released after 20 bits, then byte 06 -> exactly one toggle, for 0x06.
- Unknown opcode AB -> toggle at edge 8, KNOWN 0; with P_DCNT_W = 4, a 20-byte program load gives DCNT 15 and OVF 1.
- RESET_N low mid-frame, then 16 CS=0 bits -> no toggle and no fields change until a CS-high edge; the next frame decodes correctly.
